serial_deserializer: RTL

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/shift_pkg.sv | 14 +
 rtl/deser_out_stage.sv | 49 ++++
 rtl/serial_deserializer.sv | 108 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the serial deserializer.
package shift_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/deser_out_stage.sv
// Output holding register: valid/ready handshake plus sticky overrun flag.
module deser_out_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    input  logic             i_ovr_clr,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic             o_overrun
);

    logic w_accept;
    logic w_drop;

    // A new word fits if the holder is empty or is being drained on this edge.
    always_comb begin
        w_accept = i_load && (!o_valid || i_ready);
        w_drop   = i_load && o_valid && !i_ready;
    end

    // Holding register and valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_dout  <= '0;
            o_valid <= 1'b0;
        end else if (w_accept) begin
            o_dout  <= i_word;
            o_valid <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    // Sticky overrun; a drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_overrun <= 1'b0;
        end else if (w_drop) begin
            o_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            o_overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter: start-framed, selectable bit order, buffered output.
module serial_deserializer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic             s_valid,
    input  logic             s_din,
    input  logic             p_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_shreg;
    logic               r_dir;

    state_e             w_state_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [WIDTH-1:0]   w_shreg_nx;
    logic               w_dir_nx;
    logic               w_done;

    logic [WIDTH-1:0]   w_base;
    logic               w_sdir;
    logic [CNT_W-1:0]   w_cbase;
    logic [WIDTH-1:0]   w_shifted;
    logic [CNT_W-1:0]   w_cnt_inc;

    // State, counter, shift register and latched bit order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_dir   <= DIR_MSB_FIRST;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_shreg <= w_shreg_nx;
            r_dir   <= w_dir_nx;
        end
    end

    // Next state; a start restarts from an empty frame and may take its first bit at once.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_shreg_nx = r_shreg;
        w_dir_nx   = r_dir;
        w_done     = 1'b0;

        w_base    = start ? '0 : r_shreg;
        w_sdir    = start ? dir : r_dir;
        w_cbase   = start ? '0 : r_cnt;
        w_shifted = (w_sdir == DIR_LSB_FIRST) ? {s_din, w_base[WIDTH-1:1]}
                                              : {w_base[WIDTH-2:0], s_din};
        w_cnt_inc = w_cbase + CNT_W'(1);

        if (start) begin
            w_state_nx = RECV;
            w_dir_nx   = dir;
            w_cnt_nx   = '0;
            w_shreg_nx = '0;
            if (s_valid) begin
                w_shreg_nx = w_shifted;
                w_cnt_nx   = w_cnt_inc;
            end
        end else if (r_state == RECV && s_valid) begin
            w_shreg_nx = w_shifted;
            w_cnt_nx   = w_cnt_inc;
            if (w_cnt_inc == CNT_W'(WIDTH)) begin
                w_done     = 1'b1;
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        end
    end

    // Busy mirrors the registered state.
    assign busy = (r_state == RECV);

    // Completed words go to the buffered output stage.
    deser_out_stage #(
        .WIDTH (WIDTH)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_done),
        .i_word    (w_shifted),
        .i_ready   (p_ready),
        .i_ovr_clr (ovr_clr),
        .o_dout    (p_dout),
        .o_valid   (p_valid),
        .o_overrun (overrun)
    );

endmodule
